// File: rtl/alu_share_arbiter.sv
// Round-robin share of one alu + ALUControl pair between two requesters.
// Ports: clk, rst; r0_*/r1_* request and response channels; alu_* to/from the alu.
module alu_share_arbiter #(
  parameter int WIDTH       = 32,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [3:0]       r0_func,
  input  logic [6:0]       r0_opcode,
  output logic             r0_rsp_valid,
  input  logic             r0_rsp_ready,
  output logic [WIDTH-1:0] r0_rsp_data,
  output logic             r0_rsp_branch,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [3:0]       r1_func,
  input  logic [6:0]       r1_opcode,
  output logic             r1_rsp_valid,
  input  logic             r1_rsp_ready,
  output logic [WIDTH-1:0] r1_rsp_data,
  output logic             r1_rsp_branch,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_func,
  output logic [6:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_branch
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  logic [1:0] state;
  logic       last_grant;
  logic       owner;
  logic [3:0] cnt;
  logic       g0;
  logic       g1;
  logic       idle;
  logic       own_rsp_ready;

  // On a tie the requester that did not win last time goes next.
  assign g0 = r0_valid & (~r1_valid | last_grant);
  assign g1 = r1_valid & (~r0_valid | ~last_grant);

  assign idle     = (state == IDLE);
  assign r0_ready = ~rst & idle & g0;
  assign r1_ready = ~rst & idle & g1;

  assign r0_rsp_valid = (state == RESP) & ~owner;
  assign r1_rsp_valid = (state == RESP) & owner;

  assign own_rsp_ready = owner ? r1_rsp_ready
                               : r0_rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      cnt           <= 4'd0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_func      <= 4'd0;
      alu_opcode    <= 7'd0;
      r0_rsp_data   <= '0;
      r0_rsp_branch <= 1'b0;
      r1_rsp_data   <= '0;
      r1_rsp_branch <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            r0_ready: begin
              alu_a      <= r0_a;
              alu_b      <= r0_b;
              alu_func   <= r0_func;
              alu_opcode <= r0_opcode;
              owner      <= 1'b0;
              last_grant <= 1'b0;
              cnt        <= CNT_INIT;
              state      <= EXEC;
            end
            r1_ready: begin
              alu_a      <= r1_a;
              alu_b      <= r1_b;
              alu_func   <= r1_func;
              alu_opcode <= r1_opcode;
              owner      <= 1'b1;
              last_grant <= 1'b1;
              cnt        <= CNT_INIT;
              state      <= EXEC;
            end
            default: ;
          endcase
        end
        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (owner) begin
              r1_rsp_data   <= alu_out;
              r1_rsp_branch <= alu_branch;
            end else begin
              r0_rsp_data   <= alu_out;
              r0_rsp_branch <= alu_branch;
            end
            state <= RESP;
          end
        end
        RESP: begin
          if (own_rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
